// File: rtl/calc_seq_core.sv
// Sequential byte-serial calculator: loads two DATA_W operands over an 8-bit port, runs one ALU op, streams the result.
// Optional multiply (op 10) is enabled by defining CALC_MUL_EN.
module calc_seq_core #(
    parameter int DATA_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] op_sel,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] status,
    output logic [2:0] state
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int MSB   = DATA_W - 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NB - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    state_t            state_q;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_next;

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   sum;
    logic              alu_carry, alu_ovf, alu_err;
    logic [SH_W-1:0]   shamt;
`ifdef CALC_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    assign state    = state_q;
    assign shamt    = b_q[SH_W-1:0];
    assign idx_next = idx_q + 1'b1;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        alu_res   = '0;
        sum       = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
`ifdef CALC_MUL_EN
        prod      = '0;
`endif
        case (op_q)
            4'd0: begin
                sum       = {1'b0, a_q} + {1'b0, b_q};
                alu_res   = sum[DATA_W-1:0];
                alu_carry = sum[DATA_W];
                alu_ovf   = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            4'd1: begin
                alu_res   = a_q - b_q;
                alu_carry = a_q < b_q;
                alu_ovf   = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
            end
            4'd2: alu_res = a_q & b_q;
            4'd3: alu_res = a_q | b_q;
            4'd4: alu_res = a_q ^ b_q;
            4'd5: alu_res = ~a_q;
            4'd6: alu_res = a_q << shamt;
            4'd7: alu_res = a_q >> shamt;
            4'd8: alu_res = $signed(a_q) >>> shamt;
            4'd9: alu_res = {{(DATA_W-1){1'b0}}, a_q < b_q};
`ifdef CALC_MUL_EN
            4'd10: begin
                prod      = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
                alu_res   = prod[DATA_W-1:0];
                alu_carry = |prod[2*DATA_W-1:DATA_W];
            end
`endif
            default: alu_err = 1'b1;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            status    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (abort) begin
            // Status is deliberately kept so the last EXEC result remains observable.
            state_q   <= IDLE;
            idx_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= op_sel;
                        idx_q    <= '0;
                        state_q  <= LOAD_A;
                        in_ready <= 1'b1;
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (in_valid) begin
                        if (state_q == LOAD_A) a_q[8*idx_q +: 8] <= in_data;
                        else                   b_q[8*idx_q +: 8] <= in_data;
                        if (idx_q == LAST) begin
                            idx_q <= '0;
                            if (state_q == LOAD_A) begin
                                state_q <= LOAD_B;
                            end else begin
                                state_q  <= EXEC;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_next;
                        end
                    end
                end
                EXEC: begin
                    res_q     <= alu_res;
                    status    <= {alu_err, alu_ovf, alu_carry, alu_res == '0};
                    idx_q     <= '0;
                    out_valid <= 1'b1;
                    out_data  <= alu_res[7:0];
                    state_q   <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx_q == LAST) begin
                            idx_q     <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            state_q   <= IDLE;
                        end else begin
                            idx_q    <= idx_next;
                            out_data <= res_q[8*idx_next +: 8];
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end
            endcase
        end
    end

endmodule
